test_tag_sink_checker: RTL

- Next-generation test sink for tagged out-of-order response streams. Sits at the end of a val/rdy channel in unit-test harnesses, opposite a test source.
- Generalised over tag count, tag field position, per-tag stream depth and random backpressure. Adds per-tag expected-length tables, an error counter with first-error capture, and an inactivity watchdog.
- The bench preloads the expected-message memory and the per-tag length table hierarchically before releasing reset.

---
 rtl/test_tag_sink_pkg.sv | 35 +++
 rtl/test_rand_delay_gen.sv | 83 ++++++++
 rtl/test_tag_sink_checker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/test_tag_sink_pkg.sv
// rtl/test_tag_sink_pkg.sv - shared constants, types and helpers for the tagged test sink
// Contents:
//   LFSR_TAPS   : Galois right-shift mask for x^16+x^14+x^13+x^11+1
//   ERR_CNT_W   : width of the saturating error counter
//   clog2       : ceiling log2 usable in parameter expressions
//   lfsr_next   : one step of the 16-bit LFSR
//   dly_state_e : states of the random-delay FSM
package test_tag_sink_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        DLY_LOAD,
        DLY_WAIT,
        DLY_READY
    } dly_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
    endfunction

endpackage

// File: rtl/test_rand_delay_gen.sv
// rtl/test_rand_delay_gen.sv - LFSR-driven random ready generator for test sinks/sources
// Ports:
//   clk_i   : clock
//   reset_i : synchronous active-low reset
//   fire_i  : handshake completed this cycle (val & rdy)
//   stop_i  : suppress ready (stream finished)
//   rdy_o   : ready, low during reset and for random gaps between acceptances
module test_rand_delay_gen
    import test_tag_sink_pkg::*;
#(
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic fire_i,
    input  logic stop_i,
    output logic rdy_o
);

    localparam int CW = clog2(p_max_delay + 1) + 1;

    dly_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [CW-1:0] draw;
    logic          rdy_int;

    assign draw = CW'(lfsr_q % 16'(p_max_delay + 1));

    // The gap after each acceptance is drawn on the accepting cycle itself, so a
    // zero draw keeps ready high back-to-back. LOAD is only visited after reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        rdy_int = 1'b0;
        case (state_q)
            DLY_LOAD: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (draw == '0) begin
                    state_d = DLY_READY;
                end else begin
                    cnt_d   = draw;
                    state_d = DLY_WAIT;
                end
            end
            DLY_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DLY_READY;
                end
            end
            DLY_READY: begin
                rdy_int = !stop_i;
                if (fire_i) begin
                    lfsr_d = lfsr_next(lfsr_q);
                    if (draw != '0) begin
                        cnt_d   = draw;
                        state_d = DLY_WAIT;
                    end
                end
            end
            default: state_d = DLY_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= DLY_LOAD;
            cnt_q   <= '0;
            lfsr_q  <= p_seed;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Gated by reset so ready is low for the whole time reset is held.
    assign rdy_o = rdy_int & reset_i;

endmodule

// File: rtl/test_tag_sink_checker.sv
// rtl/test_tag_sink_checker.sv - tagged out-of-order response sink with per-tag checking
// Ports:
//   clk, reset (sync, active low)     : clock and reset
//   val, rdy, msg                     : incoming message channel
//   done                              : all tags received their expected count
//   error, num_errors, err_msg        : sticky error, saturating count, first bad message
//   timeout                           : sticky inactivity watchdog
// Tables m (expected messages, indexed {tag,index}) and len (count per tag) are
// loaded from outside before reset is released and survive reset.
module test_tag_sink_checker
    import test_tag_sink_pkg::*;
#(
    parameter int          p_msg_nbits       = 32,
    parameter int          p_tag_nbits       = 2,
    parameter int          p_tag_offset      = 0,
    parameter int          p_entries_per_tag = 16,
    parameter int          p_max_delay       = 0,
    parameter logic [15:0] p_seed            = 16'hACE1,
    parameter int          p_timeout         = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_msg_nbits-1:0] msg,
    output logic                   done,
    output logic                   error,
    output logic [ERR_CNT_W-1:0]   num_errors,
    output logic [p_msg_nbits-1:0] err_msg,
    output logic                   timeout
);

    localparam int NT = 1 << p_tag_nbits;
    localparam int IW = clog2(p_entries_per_tag);
    localparam int LW = IW + 1;
    localparam int NE = NT * p_entries_per_tag;

    logic [p_msg_nbits-1:0] m   [NE];
    logic [LW-1:0]          len [NT];

    logic [LW-1:0]          ptr_q [NT];
    logic [LW-1:0]          ptr_d [NT];
    logic                   error_q, error_d;
    logic [ERR_CNT_W-1:0]   num_errors_q, num_errors_d;
    logic [p_msg_nbits-1:0] err_msg_q, err_msg_d;
    logic                   timeout_q, timeout_d;
    logic [31:0]            idle_q, idle_d;

    logic [p_tag_nbits-1:0] tag;
    logic [LW-1:0]          cur_ptr;
    logic [LW-1:0]          cur_len;
    logic [p_msg_nbits-1:0] exp_msg;
    logic                   overflow;
    logic                   fire;
    logic                   err_ev;
    logic                   done_all;

    // Tables hold their contents; their values are written hierarchically.
    always_ff @(posedge clk) begin
        m   <= m;
        len <= len;
    end

    assign tag      = msg[p_tag_offset +: p_tag_nbits];
    assign cur_ptr  = ptr_q[tag];
    assign cur_len  = len[tag];
    assign overflow = (cur_ptr >= cur_len);
    assign exp_msg  = m[{tag, cur_ptr[IW-1:0]}];
    assign fire     = val & rdy;
    assign err_ev   = fire & (overflow | (msg != exp_msg));

    always_comb begin
        done_all = 1'b1;
        for (int t = 0; t < NT; t++) begin
            if (ptr_q[t] != len[t]) begin
                done_all = 1'b0;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (fire && !overflow) begin
            ptr_d[tag] = cur_ptr + 1'b1;
        end
    end

    always_comb begin
        error_d      = error_q | err_ev;
        num_errors_d = num_errors_q;
        err_msg_d    = err_msg_q;
        if (err_ev && (num_errors_q != '1)) begin
            num_errors_d = num_errors_q + 1'b1;
        end
        if (err_ev && !error_q) begin
            err_msg_d = msg;
        end
    end

    // Idle counter saturates at the threshold so the flag cannot be missed by wrap.
    always_comb begin
        if (fire || done_all) begin
            idle_d = '0;
        end else if (idle_q != 32'(p_timeout)) begin
            idle_d = idle_q + 32'd1;
        end else begin
            idle_d = idle_q;
        end
        timeout_d = timeout_q | ((p_timeout != 0) && (idle_d == 32'(p_timeout)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int t = 0; t < NT; t++) begin
                ptr_q[t] <= '0;
            end
            error_q      <= 1'b0;
            num_errors_q <= '0;
            err_msg_q    <= '0;
            timeout_q    <= 1'b0;
            idle_q       <= '0;
        end else begin
            ptr_q        <= ptr_d;
            error_q      <= error_d;
            num_errors_q <= num_errors_d;
            err_msg_q    <= err_msg_d;
            timeout_q    <= timeout_d;
            idle_q       <= idle_d;
        end
    end

    test_rand_delay_gen #(
        .p_max_delay (p_max_delay),
        .p_seed      (p_seed)
    ) u_delay (
        .clk_i   (clk),
        .reset_i (reset),
        .fire_i  (fire),
        .stop_i  (done_all),
        .rdy_o   (rdy)
    );

    assign done       = done_all;
    assign error      = error_q;
    assign num_errors = num_errors_q;
    assign err_msg    = err_msg_q;
    assign timeout    = timeout_q;

endmodule
